// File: rtl/line_fifo_if.sv
// Handshake and status bundle between the parser/solver side and line_fifo.
// master drives records and pops; slave is the FIFO itself.
interface line_fifo_if #(
  parameter int unsigned DATA_WIDTH = 1024,
  parameter int unsigned OPT_WIDTH  = 7,
  parameter int unsigned DEPTH      = 16
);
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH) + 1;

  logic                  parser_valid;
  logic [DATA_WIDTH-1:0] parser_data;
  logic [OPT_WIDTH-1:0]  parser_opts;
  logic                  parser_ready;
  logic                  write_to_fifo;
  logic [DATA_WIDTH-1:0] solver_data;
  logic [OPT_WIDTH-1:0]  solver_opts;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] read_FIFO;
  logic [OPT_WIDTH-1:0]  options_per_line;
  logic                  rd_en;
  logic [CNT_WIDTH-1:0]  count;
  logic                  overflow;
  logic [CNT_WIDTH-1:0]  high_water;
  logic [15:0]           push_total;

  modport master (
    output parser_valid, parser_data, parser_opts, write_to_fifo, solver_data, solver_opts,
           rd_en,
    input  parser_ready, valid_out, read_FIFO, options_per_line, count, overflow, high_water,
           push_total
  );

  modport slave (
    input  parser_valid, parser_data, parser_opts, write_to_fifo, solver_data, solver_opts,
           rd_en,
    output parser_ready, valid_out, read_FIFO, options_per_line, count, overflow, high_water,
           push_total
  );
endinterface

// File: rtl/line_fifo.sv
// First-word-fall-through line FIFO fed by a parser and a recirculating solver.
// Optional statistics counters are built only when LINE_FIFO_STATS_EN is defined.
module line_fifo #(
  parameter int unsigned DATA_WIDTH = 1024,
  parameter int unsigned OPT_WIDTH  = 7,
  parameter int unsigned DEPTH      = 16
) (
  input logic        clk,
  input logic        rst,
  line_fifo_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned RecW = DATA_WIDTH + OPT_WIDTH;
  localparam logic [CntW-1:0] Full       = CntW'(DEPTH);
  localparam logic [CntW-1:0] ParserStop = CntW'(DEPTH - 1);

  logic [RecW-1:0] mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;

  logic            not_empty;
  logic            pop;
  logic            parser_ready;
  logic            parser_accept;
  logic            solver_accept;
  logic            push;
  logic [RecW-1:0] wr_rec;
  logic [RecW-1:0] head_rec;

  // Parser never takes the last slot, so a solver recirculation always has room.
  assign not_empty     = (count_q != '0);
  assign pop           = not_empty && bus.rd_en;
  assign parser_ready  = !bus.write_to_fifo && (count_q < ParserStop);
  assign parser_accept = bus.parser_valid && parser_ready;
  assign solver_accept = bus.write_to_fifo && ((count_q < Full) || pop);
  assign push          = parser_accept || solver_accept;
  assign wr_rec        = solver_accept ? {bus.solver_opts, bus.solver_data}
                                       : {bus.parser_opts, bus.parser_data};

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (bus.write_to_fifo && !solver_accept) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; outputs are gated while empty instead.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr_q] <= wr_rec;
    end
  end

  assign head_rec             = not_empty ? mem[rd_ptr_q] : '0;
  assign bus.read_FIFO        = head_rec[DATA_WIDTH-1:0];
  assign bus.options_per_line = head_rec[RecW-1:DATA_WIDTH];
  assign bus.valid_out        = not_empty;
  assign bus.parser_ready     = parser_ready;
  assign bus.count            = count_q;
  assign bus.overflow         = overflow_q;

`ifdef LINE_FIFO_STATS_EN
  logic [CntW-1:0] high_water_q;
  logic [15:0]     push_total_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      high_water_q <= '0;
      push_total_q <= '0;
    end else begin
      if (count_d > high_water_q) begin
        high_water_q <= count_d;
      end
      if (push && (push_total_q != 16'hFFFF)) begin
        push_total_q <= push_total_q + 16'd1;
      end
    end
  end

  assign bus.high_water = high_water_q;
  assign bus.push_total = push_total_q;
`else
  assign bus.high_water = '0;
  assign bus.push_total = '0;
`endif

endmodule

// File: tb/tb_line_fifo.sv
// Directed self-checking bench for line_fifo using the default 1024/7/16 configuration.
// Expected records are kept in a small reference queue filled by the bench.
module tb_line_fifo;
  localparam int unsigned DW = 1024;
  localparam int unsigned OW = 7;
  localparam int unsigned DEPTH = 16;

  typedef logic [1023:0] val_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  logic [DW+OW-1:0] exp_q[$];

  line_fifo_if #(.DATA_WIDTH(DW), .OPT_WIDTH(OW), .DEPTH(DEPTH)) bus ();

  line_fifo #(.DATA_WIDTH(DW), .OPT_WIDTH(OW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input val_t obs, input val_t exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h want %0h (low 200 bits)", tag, obs[199:0], exp[199:0]);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rec_data(input int i);
    logic [DW-1:0] d;
    d = '0;
    d[15:0]     = 16'hC000 + 16'(i);
    d[1023:1008] = 16'h3000 + 16'(i);
    return d;
  endfunction

  function automatic logic [OW-1:0] rec_opts(input int i);
    return OW'(i % 8);
  endfunction

  task automatic idle_inputs();
    bus.parser_valid  = 1'b0;
    bus.parser_data   = '0;
    bus.parser_opts   = '0;
    bus.write_to_fifo = 1'b0;
    bus.solver_data   = '0;
    bus.solver_opts   = '0;
    bus.rd_en         = 1'b0;
  endtask

  task automatic check_head(input string tag);
    check({tag, "_valid"}, val_t'(bus.valid_out), val_t'(1));
    check({tag, "_data"}, val_t'(bus.read_FIFO), val_t'(exp_q[0][DW-1:0]));
    check({tag, "_opts"}, val_t'(bus.options_per_line), val_t'(exp_q[0][DW+OW-1:DW]));
  endtask

  initial begin
    logic [DW-1:0] d31;
    int            fills;
    n_checks = 0;
    n_pass   = 0;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_count", val_t'(bus.count), val_t'(0));
    check("rst_valid", val_t'(bus.valid_out), val_t'(0));
    check("rst_data", val_t'(bus.read_FIFO), val_t'(0));
    check("rst_opts", val_t'(bus.options_per_line), val_t'(0));
    check("rst_ovf", val_t'(bus.overflow), val_t'(0));
    check("rst_hw", val_t'(bus.high_water), val_t'(0));
    check("rst_pt", val_t'(bus.push_total), val_t'(0));
    check("rst_pready", val_t'(bus.parser_ready), val_t'(1));
    bus.write_to_fifo = 1'b1;
    #1;
    check("rst_pready_wr", val_t'(bus.parser_ready), val_t'(0));
    bus.write_to_fifo = 1'b0;
    #1;

    // First parser write, visible only after the edge
    d31 = '0;
    d31[13:0] = 14'b10001000100001;
    bus.parser_valid = 1'b1;
    bus.parser_data  = d31;
    bus.parser_opts  = 7'd3;
    #1;
    check("first_no_bypass", val_t'(bus.valid_out), val_t'(0));
    step();
    idle_inputs();
    #1;
    check("first_valid", val_t'(bus.valid_out), val_t'(1));
    check("first_data", val_t'(bus.read_FIFO), val_t'(d31));
    check("first_opts", val_t'(bus.options_per_line), val_t'(3));
    check("first_count", val_t'(bus.count), val_t'(1));
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    #1;
    check("first_pop_count", val_t'(bus.count), val_t'(0));

    // Parser fills until it stalls one short of full
    fills = 0;
    for (int i = 0; i < 20; i++) begin
      bus.parser_valid = 1'b1;
      bus.parser_data  = rec_data(i);
      bus.parser_opts  = rec_opts(i);
      #1;
      if (!bus.parser_ready) break;
      exp_q.push_back({rec_opts(i), rec_data(i)});
      fills++;
      step();
    end
    check("fill_parser_n", val_t'(fills), val_t'(15));
    check("fill_count15", val_t'(bus.count), val_t'(15));
    check("fill_pready", val_t'(bus.parser_ready), val_t'(0));
    bus.parser_valid  = 1'b0;
    bus.write_to_fifo = 1'b1;
    bus.solver_data   = rec_data(50);
    bus.solver_opts   = rec_opts(50);
    exp_q.push_back({rec_opts(50), rec_data(50)});
    step();
    check("fill_count16", val_t'(bus.count), val_t'(16));
    check("fill_ovf", val_t'(bus.overflow), val_t'(0));

    // Full: dropped write sets overflow, write with pop is accepted
    bus.solver_data = rec_data(51);
    bus.solver_opts = rec_opts(51);
    step();
    check("drop_count", val_t'(bus.count), val_t'(16));
    check("drop_ovf", val_t'(bus.overflow), val_t'(1));
    check_head("drop_head");
    bus.solver_data = rec_data(52);
    bus.solver_opts = rec_opts(52);
    bus.rd_en       = 1'b1;
    #1;
    check_head("fullpop_head");
    step();
    void'(exp_q.pop_front());
    exp_q.push_back({rec_opts(52), rec_data(52)});
    idle_inputs();
    #1;
    check("fullpop_count", val_t'(bus.count), val_t'(16));
    check("fullpop_ovf", val_t'(bus.overflow), val_t'(1));
`ifdef LINE_FIFO_STATS_EN
    check("mid_hw", val_t'(bus.high_water), val_t'(16));
    check("mid_pt", val_t'(bus.push_total), val_t'(18));
`else
    check("mid_hw", val_t'(bus.high_water), val_t'(0));
    check("mid_pt", val_t'(bus.push_total), val_t'(0));
`endif

    // Drain 11 in order, leaving 5
    for (int k = 0; k < 11; k++) begin
      check_head("drain");
      bus.rd_en = 1'b1;
      step();
      void'(exp_q.pop_front());
    end
    bus.rd_en = 1'b0;
    #1;
    check("drain_count5", val_t'(bus.count), val_t'(5));

    // Reset overrides a simultaneous write and pop
    rst = 1'b1;
    bus.write_to_fifo = 1'b1;
    bus.solver_data   = rec_data(60);
    bus.solver_opts   = rec_opts(60);
    bus.rd_en         = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    exp_q.delete();
    #1;
    check("rst5_count", val_t'(bus.count), val_t'(0));
    check("rst5_valid", val_t'(bus.valid_out), val_t'(0));
    check("rst5_data", val_t'(bus.read_FIFO), val_t'(0));
    check("rst5_opts", val_t'(bus.options_per_line), val_t'(0));
    check("rst5_ovf", val_t'(bus.overflow), val_t'(0));
    check("rst5_hw", val_t'(bus.high_water), val_t'(0));

    // 40 records, alternating sources, continuous pop across pointer wrap
    for (int i = 0; i <= 40; i++) begin
      idle_inputs();
      bus.rd_en = 1'b1;
      if (i < 40) begin
        if (i % 2 == 0) begin
          bus.parser_valid = 1'b1;
          bus.parser_data  = rec_data(100 + i);
          bus.parser_opts  = rec_opts(100 + i);
        end else begin
          bus.write_to_fifo = 1'b1;
          bus.solver_data   = rec_data(100 + i);
          bus.solver_opts   = rec_opts(100 + i);
        end
      end
      #1;
      if (i > 0) check_head("stream");
      step();
      if (i > 0) void'(exp_q.pop_front());
      if (i < 40) exp_q.push_back({rec_opts(100 + i), rec_data(100 + i)});
    end
    idle_inputs();
    #1;
    check("stream_count", val_t'(bus.count), val_t'(0));
`ifdef LINE_FIFO_STATS_EN
    check("stream_pt", val_t'(bus.push_total), val_t'(40));
    check("stream_hw", val_t'(bus.high_water), val_t'(1));
`else
    check("stream_pt", val_t'(bus.push_total), val_t'(0));
    check("stream_hw", val_t'(bus.high_water), val_t'(0));
`endif

    // Solver wins over parser in the same cycle
    bus.parser_valid  = 1'b1;
    bus.parser_data   = rec_data(200);
    bus.parser_opts   = rec_opts(200);
    bus.write_to_fifo = 1'b1;
    bus.solver_data   = rec_data(201);
    bus.solver_opts   = 7'd0;
    #1;
    check("prio_pready", val_t'(bus.parser_ready), val_t'(0));
    step();
    exp_q.push_back({7'd0, rec_data(201)});
    bus.write_to_fifo = 1'b0;
    #1;
    check("prio_count1", val_t'(bus.count), val_t'(1));
    check("prio_pready2", val_t'(bus.parser_ready), val_t'(1));
    check_head("prio_solver");
    step();
    exp_q.push_back({rec_opts(200), rec_data(200)});
    idle_inputs();
    #1;
    check("prio_count2", val_t'(bus.count), val_t'(2));
    for (int k = 0; k < 2; k++) begin
      check_head("prio_drain");
      bus.rd_en = 1'b1;
      step();
      void'(exp_q.pop_front());
    end
    bus.rd_en = 1'b0;
    #1;
    check("end_valid", val_t'(bus.valid_out), val_t'(0));
    check("end_data", val_t'(bus.read_FIFO), val_t'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/line_fifo.md
LINE_FIFO -- requirements
Module: line_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 1024: width of one packed line-options record.
REQ-002 Parameter OPT_WIDTH, default 7: width of the options-per-line count.
REQ-003 Parameter DEPTH, default 16: number of entries; SHALL be a power of two, at least 4.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 parser_valid  input  1  parser offers a new line record.
REQ-007 parser_data / parser_opts  input  DATA_WIDTH / OPT_WIDTH  parser record and its option count.
REQ-008 parser_ready  output  1  parser record accepted this cycle when high with parser_valid.
REQ-009 write_to_fifo  input  1  solver recirculates a simplified line; no backpressure.
REQ-010 solver_data / solver_opts  input  DATA_WIDTH / OPT_WIDTH  recirculated record and its option count.
REQ-011 valid_out  output  1  head entry present, equals not-empty.
REQ-012 read_FIFO / options_per_line  output  DATA_WIDTH / OPT_WIDTH  head record and count; zero when valid_out low.
REQ-013 rd_en  input  1  solver pops head; ignored when valid_out low.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 overflow  output  1  sticky: a solver write was dropped.
REQ-016 high_water / push_total  output  $clog2(DEPTH)+1 / 16  statistics (see Configuration).

Function
REQ-017 First-word-fall-through: head visible on read_FIFO while valid_out high; pop occurs on valid_out && rd_en.
REQ-018 A write accepted in cycle N SHALL be visible at the outputs in cycle N+1; no same-cycle bypass when empty.
REQ-019 Solver write has priority: parser_ready SHALL be low in any cycle with write_to_fifo high.
REQ-020 parser_ready = !write_to_fifo && (count < DEPTH-1); one slot always reserved for recirculation.
REQ-021 Solver write accepted when count < DEPTH, or when count == DEPTH with a pop in the same cycle.
REQ-022 Solver write at count == DEPTH without pop SHALL be dropped, state unchanged, overflow set until reset.
REQ-023 Simultaneous accepted write and pop: count unchanged, both pointers advance.
REQ-024 Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0; count ranges 0..DEPTH.
REQ-025 Records are stored unmodified, including option count 0 (contradiction line); ordering strictly FIFO across both write sources.

Reset
REQ-026 rst high at a clock edge SHALL override all same-cycle writes and pops.
REQ-027 After reset: pointers 0, count 0, valid_out 0, read_FIFO 0, options_per_line 0, overflow 0, high_water 0, push_total 0; parser_ready 1 unless write_to_fifo high.
REQ-028 Storage array is not reset; outputs are gated to zero while empty.

Configuration
REQ-029 Macro LINE_FIFO_STATS_EN: when defined, high_water tracks maximum count since reset and push_total counts accepted writes (both sources), saturating at 16'hFFFF.
REQ-030 Without LINE_FIFO_STATS_EN, high_water and push_total SHALL be constant 0 and the counters not synthesised; ports remain.

Verification
REQ-031 Reset, parser_valid=1 with parser_data=14'b10001000100001 zero-extended, parser_opts=3 -> next cycle valid_out=1, read_FIFO matches, options_per_line=3, count=1.
REQ-032 Parser writes until stall, no pops -> parser_ready drops at count=15; write_to_fifo then fills to count=16, overflow stays 0.
REQ-033 At count=16, write_to_fifo without rd_en -> record dropped, overflow=1, count=16; with rd_en same cycle -> accepted, count=16, overflow unchanged.
REQ-034 parser_valid and write_to_fifo together with different records -> only solver record stored; parser_ready=0 that cycle; parser record stored next cycle.
REQ-035 Push/pop 40 records alternating sources with continuous rd_en -> output order equals input order across pointer wrap; with LINE_FIFO_STATS_EN push_total=40, high_water=1.
REQ-036 rst asserted at count=5 together with write and pop -> next cycle count=0, valid_out=0, outputs zero, overflow=0.
